match_scoreboard: RTL

MATCH_SCOREBOARD -- requirements
Module: match_scoreboard

---
 rtl/match_scoreboard.sv | 136 +++++++++++++
 1 files changed

// File: rtl/match_scoreboard.sv
// Round/match scoreboard: counts round results from the game core, times the
// result display, restarts rounds, and latches the match winner.
module match_scoreboard #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int WINS_TO_MATCH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       over,
    input  logic [1:0] winner,
    input  logic       new_match,
    output logic       round_restart,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] draw_count,
    output logic       match_over,
    output logic [1:0] match_winner
);

    localparam int             CW        = 26;
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]     WINS      = 4'(WINS_TO_MATCH);
    localparam logic [3:0]     DRAW_MAX  = 4'd9;

    typedef enum logic [1:0] {
        WAIT_CLEAR = 2'd0,
        PLAY       = 2'd1,
        HOLD       = 2'd2,
        MATCH_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          over_d_q, over_d_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          rr_q, rr_d;
    logic [3:0]    p1_q, p1_d, p2_q, p2_d, dr_q, dr_d;
    logic          mo_q, mo_d;
    logic [1:0]    mw_q, mw_d;
    logic          round_end;

    assign round_end = (state_q == PLAY) && over && !over_d_q;

    always_comb begin
        state_d  = state_q;
        over_d_d = over;
        hold_d   = hold_q;
        rr_d     = 1'b0;
        p1_d     = p1_q;
        p2_d     = p2_q;
        dr_d     = dr_q;
        mo_d     = mo_q;
        mw_d     = mw_q;

        case (state_q)
            WAIT_CLEAR: if (!over) state_d = PLAY;
            PLAY: begin
                if (round_end) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                    if (winner == 2'b01) begin
                        p1_d = p1_q + 4'd1;
                        if (p1_d == WINS) begin
                            state_d = MATCH_DONE;
                            mo_d    = 1'b1;
                            mw_d    = 2'b01;
                        end
                    end else if (winner == 2'b10) begin
                        p2_d = p2_q + 4'd1;
                        if (p2_d == WINS) begin
                            state_d = MATCH_DONE;
                            mo_d    = 1'b1;
                            mw_d    = 2'b10;
                        end
                    end else if (dr_q != DRAW_MAX) begin
                        dr_d = dr_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    rr_d    = 1'b1;
                    state_d = WAIT_CLEAR;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            MATCH_DONE: ;
            default: state_d = WAIT_CLEAR;
        endcase

        // A new match overrides any same-cycle round result; the restart pulse
        // is suppressed only if one is already out, so it never stretches.
        if (new_match) begin
            state_d = WAIT_CLEAR;
            hold_d  = '0;
            rr_d    = !rr_q;
            p1_d    = '0;
            p2_d    = '0;
            dr_d    = '0;
            mo_d    = 1'b0;
            mw_d    = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_CLEAR;
            over_d_q <= 1'b0;
            hold_q   <= '0;
            rr_q     <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            dr_q     <= '0;
            mo_q     <= 1'b0;
            mw_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            over_d_q <= over_d_d;
            hold_q   <= hold_d;
            rr_q     <= rr_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            dr_q     <= dr_d;
            mo_q     <= mo_d;
            mw_q     <= mw_d;
        end
    end

    assign round_restart = rr_q;
    assign p1_score      = p1_q;
    assign p2_score      = p2_q;
    assign draw_count    = dr_q;
    assign match_over    = mo_q;
    assign match_winner  = mw_q;

endmodule
